// File: rtl/fifo_rd_stream_adapter_if.sv
// Read-side bundle between the async FIFO (rempty/rinc/rdata) and the stream consumer.
// Stream handshake: a word moves when out_valid && out_ready at a rising clk edge; while
// out_valid is high and out_ready low, out_valid and out_data stay stable.
interface fifo_rd_stream_adapter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4
);
    logic                               rempty;
    logic                               rinc;
    logic [DATA_WIDTH-1:0]              rdata;
    logic                               out_valid;
    logic                               out_ready;
    logic [DATA_WIDTH-1:0]              out_data;
    logic [$clog2(BUF_DEPTH+1)-1:0]     buf_level;

    modport master (
        input  rempty, rdata, out_ready,
        output rinc, out_valid, out_data, buf_level
    );

    modport slave (
        output rempty, rdata, out_ready,
        input  rinc, out_valid, out_data, buf_level
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the FIFO pop/empty read port into a valid/ready stream through a small FWFT skid buffer.
// Pops are paced one every two cycles so the one-cycle-stale rempty can never cause an over-read.
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    fifo_rd_stream_adapter_if.master  bus,
    output logic                      o_dbg_state
);
    localparam int LW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = LW + $clog2(RD_LATENCY + 1) + 1;

    typedef enum logic {
        ST_ARM   = 1'b0,
        ST_BLOCK = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [RD_LATENCY-1:0] r_pipe;
    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [LW-1:0]         r_level;
    logic [CW-1:0]         w_inflight;
    logic [CW-1:0]         w_committed;
    logic                  w_credit_ok;
    logic                  w_rinc;
    logic                  w_push;
    logic                  w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // The landing stage still counts as in flight, so a same-cycle drain never frees credit early.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_pipe[i]);
        end
    end

    assign w_committed = CW'(r_level) + w_inflight;
    assign w_credit_ok = (w_committed < CW'(BUF_DEPTH));

    always_comb begin
        w_state_next = r_state;
        w_rinc       = 1'b0;
        case (r_state)
            ST_ARM: begin
                w_rinc = !rst && !bus.rempty && w_credit_ok;
                if (w_rinc) begin
                    w_state_next = ST_BLOCK;
                end
            end
            ST_BLOCK: begin
                w_state_next = ST_ARM;
            end
            default: begin
                w_state_next = ST_ARM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ARM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_rinc;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_push = r_pipe[RD_LATENCY-1];
    assign w_pop  = (r_level != '0) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once level says it was written.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_tail] <= bus.rdata;
        end
    end

    assign bus.rinc      = w_rinc;
    assign bus.out_valid = (r_level != '0);
    assign bus.out_data  = (r_level != '0) ? r_mem[r_head] : '0;
    assign bus.buf_level = r_level;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: runs RD_LATENCY=1 and RD_LATENCY=2 instances side by side,
// each behind its own FIFO read-port model, with an expected-word queue and an occupancy model.
module tb_fifo_rd_stream_adapter;
  localparam int DW = 8;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          out_ready = 1'b0;
  logic          mon_on = 1'b0;
  logic [DW-1:0] src_mem [0:1023];
  int            wp = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  logic [1:0]        rinc_v;
  logic [1:0]        ov_v;
  logic [1:0][2:0]   lvl_v;
  logic [1:0][DW-1:0] od_v;
  logic [1:0][15:0]  rcnt_v;
  logic [1:0][15:0]  xcnt_v;
  logic [1:0][15:0]  qsz_v;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // write side of the FIFO, shared by both instances
  always @(posedge clk) begin
    if (wr_en) begin
      src_mem[wp] <= wr_data;
      wp <= wp + 1;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int LAT = k + 1;

    fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) bus ();
    logic          dbg_state;
    logic          prev_state = 1'b0;
    logic [DW-1:0] p1 = '0;
    logic [DW-1:0] p2 = '0;
    int            rp = 0;
    logic [DW-1:0] exp_q[$];
    int            exp_lvl = 0;
    logic [3:0]    hist = '0;
    int            rinc_cnt = 0;
    int            xfer_cnt = 0;
    int            qsz = 0;

    fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .RD_LATENCY(LAT), .BUF_DEPTH(BD)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .o_dbg_state(dbg_state)
    );

    assign bus.out_ready = out_ready;
    assign bus.rdata     = (LAT == 1) ? p1 : p2;
    assign rinc_v[k]     = bus.rinc;
    assign ov_v[k]       = bus.out_valid;
    assign lvl_v[k]      = bus.buf_level;
    assign od_v[k]       = bus.out_data;
    assign rcnt_v[k]     = 16'(rinc_cnt);
    assign xcnt_v[k]     = 16'(xfer_cnt);
    assign qsz_v[k]      = 16'(qsz);

    // FIFO read port: empty flag registered from the pointers as they were before this edge
    always @(posedge clk) begin
      bus.rempty <= flush ? 1'b1 : (wp == rp);
      p1 <= bus.rinc ? src_mem[rp] : 8'($urandom);
      p2 <= p1;
      if (flush) rp <= wp;
      else if (bus.rinc) rp <= rp + 1;
    end

    // scoreboard + occupancy reference: a pop issued at cycle c is counted at cycle c+LAT+1
    always @(negedge clk) begin
      logic xfer;
      int   infl;
      if (mon_on) begin
        infl = 0;
        for (int i = 0; i < LAT; i++) infl += int'(hist[i]);
        check($sformatf("L%0d buf_level", LAT), 32'(bus.buf_level), 32'(exp_lvl));
        check($sformatf("L%0d out_valid", LAT), 32'(bus.out_valid), 32'(exp_lvl != 0));
        check($sformatf("L%0d level_plus_inflight", LAT), 32'(exp_lvl + infl <= BD), 32'd1);
        check($sformatf("L%0d back_to_back_rinc", LAT), 32'(bus.rinc && hist[0]), 32'd0);
        check($sformatf("L%0d rinc_while_empty", LAT), 32'(bus.rinc && bus.rempty), 32'd0);
        if (rst) check($sformatf("L%0d rinc_in_reset", LAT), 32'(bus.rinc), 32'd0);
        if (hist[0]) check($sformatf("L%0d state_after_pop", LAT), 32'(dbg_state !== prev_state), 32'd1);
        xfer = bus.out_valid && out_ready && !rst;
        if (xfer) begin
          if (exp_q.size() == 0) begin
            check($sformatf("L%0d unexpected_word", LAT), 32'(bus.out_data), 32'hFFFF_FFFF);
          end else begin
            check($sformatf("L%0d out_data", LAT), 32'(bus.out_data), 32'(exp_q.pop_front()));
          end
          xfer_cnt++;
        end
        if (bus.rinc) rinc_cnt++;
        if (rst) begin
          exp_lvl = 0;
          hist = '0;
        end else begin
          exp_lvl = exp_lvl + int'(hist[LAT-1]) - int'(xfer);
          hist = {hist[2:0], bus.rinc};
        end
        if (flush) exp_q.delete();
        else if (wr_en) exp_q.push_back(wr_data);
        qsz = exp_q.size();
        prev_state = dbg_state;
      end
    end
  end

  // driver tasks
  task automatic push_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = base + DW'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 150 && (qsz_v[0] != 0 || qsz_v[1] != 0); i++) step();
    for (int k = 0; k < 2; k++) check($sformatf("%s L%0d words_left", tag, k + 1), 32'(qsz_v[k]), 32'd0);
  endtask

  initial begin
    logic [1:0][15:0] r0, x0;
    int first [2];
    logic found;

    // 1: reset with data already waiting in the FIFO
    step();
    mon_on = 1'b1;
    out_ready = 1'b1;
    push_words(8'h11, 3);
    step();
    step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t1 L%0d rinc", k + 1), 32'(rinc_v[k]), 32'd0);
      check($sformatf("t1 L%0d out_valid", k + 1), 32'(ov_v[k]), 32'd0);
      check($sformatf("t1 L%0d buf_level", k + 1), 32'(lvl_v[k]), 32'd0);
      check($sformatf("t1 L%0d out_data", k + 1), 32'(od_v[k]), 32'd0);
    end

    // 2: stream 0x11,0x22,0x33; pops at t,t+2,t+4, first word visible at t+LAT+1
    step();
    rst = 1'b0;
    first[0] = -1;
    first[1] = -1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("t2 L%0d rinc c%0d", k + 1, c), 32'(rinc_v[k]), 32'(c < 6 && c % 2 == 0));
        if (ov_v[k] && first[k] < 0) first[k] = c;
      end
    end
    for (int k = 0; k < 2; k++) check($sformatf("t2 L%0d first_valid", k + 1), 32'(first[k]), 32'(k + 2));
    drain("t2");

    // 3: backpressure, six words queued
    out_ready = 1'b0;
    step();
    r0 = rcnt_v;
    x0 = xcnt_v;
    push_words(8'hA0, 6);
    for (int i = 0; i < 24; i++) step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t3 L%0d pops", k + 1), 32'(rcnt_v[k] - r0[k]), 32'd4);
      check($sformatf("t3 L%0d buf_level", k + 1), 32'(lvl_v[k]), 32'd4);
      check($sformatf("t3 L%0d rinc_held", k + 1), 32'(rinc_v[k]), 32'd0);
    end
    drain("t3");
    for (int k = 0; k < 2; k++) check($sformatf("t3 L%0d delivered", k + 1), 32'(xcnt_v[k] - x0[k]), 32'd6);

    // 4: single word, empty flag returns right after the pop
    r0 = rcnt_v;
    x0 = xcnt_v;
    push_words(8'h5A, 1);
    for (int i = 0; i < 15; i++) step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t4 L%0d pops", k + 1), 32'(rcnt_v[k] - r0[k]), 32'd1);
      check($sformatf("t4 L%0d delivered", k + 1), 32'(xcnt_v[k] - x0[k]), 32'd1);
    end

    // 5: pop and land in the same cycle at level 3
    out_ready = 1'b0;
    push_words(8'hC0, 4);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (rinc_v[0] && lvl_v[0] == 3'd3) found = 1'b1;
    end
    check("t5 setup_level3_inflight1", 32'(found), 32'd1);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("t5 L1 level_at_landing", 32'(lvl_v[0]), 32'd3);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("t5 L1 level_after_swap", 32'(lvl_v[0]), 32'd3);
    check("t5 L1 head_word", 32'(od_v[0]), 32'hC1);
    drain("t5");

    // 6: reset with two words buffered and one in flight
    out_ready = 1'b0;
    push_words(8'hE0, 3);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (rinc_v[0] && lvl_v[0] == 3'd2) found = 1'b1;
    end
    check("t6 setup_level2_inflight1", 32'(found), 32'd1);
    step();
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("t6 L%0d level c%0d", k + 1, c), 32'(lvl_v[k]), 32'd0);
        check($sformatf("t6 L%0d out_valid c%0d", k + 1, c), 32'(ov_v[k]), 32'd0);
      end
    end

    // random traffic: first heavy backpressure, then mostly ready
    for (int i = 0; i < 500; i++) begin
      wr_en = ($urandom_range(0, 2) == 0) && (wp < 1000);
      wr_data = 8'($urandom);
      out_ready = (i < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end
    wr_en = 1'b0;
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
